// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that locks one byte-stream requester onto the UART TX FIFO
// until its packet ends or the burst limit is reached.
module uart_tx_arb #(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned MaxBurst = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  clr_i,
    input  logic [NumReq-1:0]     req_valid_i,
    input  logic [8*NumReq-1:0]   req_data_i,
    input  logic [NumReq-1:0]     req_last_i,
    output logic [NumReq-1:0]     req_ready_o,
    output logic                  fifo_wvalid_o,
    output logic [7:0]            fifo_wdata_o,
    input  logic                  fifo_wready_i,
    output logic [NumReq-1:0]     grant_o,
    output logic                  busy_o
);

    localparam int unsigned OwnW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = $clog2(MaxBurst);

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t            state;
    logic [OwnW-1:0]   owner;
    logic [OwnW-1:0]   rr_ptr;
    logic [CntW-1:0]   burst_cnt;

    logic [OwnW-1:0]   pick;
    logic [OwnW-1:0]   cand;
    logic [OwnW-1:0]   rr_next;
    logic              any_req;
    logic              lock;
    logic              beat;
    logic              done;

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        pick    = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = OwnW'((32'(rr_ptr) + i) % NumReq);
            if (!any_req && req_valid_i[cand]) begin
                pick    = cand;
                any_req = 1'b1;
            end
        end
    end

    // clr_i suppresses the handshake in its own cycle; data still follows the owner.
    always_comb begin
        lock          = (state == LOCK);
        busy_o        = lock;
        grant_o       = '0;
        req_ready_o   = '0;
        fifo_wvalid_o = 1'b0;
        fifo_wdata_o  = '0;
        if (lock) begin
            grant_o[owner] = 1'b1;
            fifo_wdata_o   = req_data_i[{owner, 3'b000} +: 8];
            if (!clr_i) begin
                fifo_wvalid_o      = req_valid_i[owner];
                req_ready_o[owner] = fifo_wready_i;
            end
        end
        beat    = fifo_wvalid_o && fifo_wready_i;
        done    = beat && (req_last_i[owner] || (burst_cnt == CntW'(MaxBurst - 1)));
        rr_next = (owner == OwnW'(NumReq - 1)) ? '0 : owner + OwnW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else if (clr_i) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i && any_req) begin
                        owner     <= pick;
                        burst_cnt <= '0;
                        state     <= LOCK;
                    end
                end
                LOCK: begin
                    if (beat) begin
                        burst_cnt <= burst_cnt + CntW'(1);
                    end
                    if (done) begin
                        state  <= IDLE;
                        rr_ptr <= rr_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized scoreboard bench for uart_tx_arb: a packet-level reference model
// predicts per-cycle outputs and accepted bytes; a monitor compares them.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int MB = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             clr;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             fifo_wvalid;
    logic [7:0]       fifo_wdata;
    logic             fifo_wready;
    logic [N-1:0]     grant;
    logic             busy;

    uart_tx_arb #(.NumReq(N), .MaxBurst(MB)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (enable),
        .clr_i         (clr),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_last_i    (req_last),
        .req_ready_o   (req_ready),
        .fifo_wvalid_o (fifo_wvalid),
        .fifo_wdata_o  (fifo_wdata),
        .fifo_wready_i (fifo_wready),
        .grant_o       (grant),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         busy;
        logic [N-1:0] grant;
        logic         wvalid;
        logic [7:0]   wdata;
        logic [N-1:0] ready;
    } status_t;

    typedef struct packed {
        logic [N-1:0] grant;
        logic [7:0]   data;
    } beat_t;

    status_t      st_q[$];
    beat_t        beat_q[$];
    logic [8:0]   pkt_q[N][$];
    logic [N-1:0] acc = '0;

    int n_checks = 0;
    int n_pass   = 0;

    int valid_pct, wready_pct, enable_pct, clr_pct, refill_pct, max_len, nolast_pct;
    logic [N-1:0] refill_mask;

    // Reference model state: owner = -1 means no grant held.
    int m_owner = -1;
    int m_rr    = 0;
    int m_cnt   = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic make_packet(input int r, input int len, input bit nolast);
        for (int b = 0; b < len; b++)
            pkt_q[r].push_back({(b == len - 1) && !nolast, 8'($urandom)});
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (pkt_q[i].size() > 0 && ($urandom % 100) < valid_pct) begin
                req_valid[i]         = 1'b1;
                req_data[8*i +: 8]   = pkt_q[i][0][7:0];
                req_last[i]          = pkt_q[i][0][8];
            end else begin
                req_valid[i]         = 1'b0;
                req_data[8*i +: 8]   = 8'($urandom);
                req_last[i]          = 1'($urandom);
            end
        end
        fifo_wready = ($urandom % 100) < wready_pct;
        enable      = ($urandom % 100) < enable_pct;
        clr         = ($urandom % 100) < clr_pct;
    endtask

    task automatic pop_accepted();
        for (int i = 0; i < N; i++)
            if (acc[i] && pkt_q[i].size() > 0) void'(pkt_q[i].pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        pop_accepted();
        for (int i = 0; i < N; i++)
            if (refill_mask[i] && pkt_q[i].size() == 0 && ($urandom % 100) < refill_pct)
                make_packet(i, $urandom_range(1, max_len), ($urandom % 100) < nolast_pct);
        drive();
    endtask

    task automatic run(input int cycles);
        repeat (cycles) step();
    endtask

    task automatic set_cfg(input int v, input int w, input int e, input int c,
                           input logic [N-1:0] m, input int rp, input int ml, input int nl);
        valid_pct = v; wready_pct = w; enable_pct = e; clr_pct = c;
        refill_mask = m; refill_pct = rp; max_len = ml; nolast_pct = nl;
    endtask

    // Reference model: evaluated mid-cycle while inputs are stable.
    initial forever begin
        status_t e;
        bit      beat;
        @(negedge clk);
        acc  = req_valid & req_ready;
        e    = '0;
        beat = 1'b0;
        if (!rst_n) begin
            m_owner = -1; m_rr = 0; m_cnt = 0;
            st_q.push_back(e);
        end else begin
            if (m_owner >= 0) begin
                e.busy           = 1'b1;
                e.grant[m_owner] = 1'b1;
                e.wdata          = req_data[8*m_owner +: 8];
                if (!clr) begin
                    e.wvalid         = req_valid[m_owner];
                    e.ready[m_owner] = fifo_wready;
                end
            end
            beat = e.wvalid && fifo_wready;
            st_q.push_back(e);
            if (beat) beat_q.push_back({e.grant, e.wdata});
            if (clr) begin
                m_owner = -1; m_rr = 0; m_cnt = 0;
            end else if (m_owner < 0) begin
                if (enable) begin
                    for (int k = 0; k < N; k++)
                        if (m_owner < 0 && req_valid[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
                    m_cnt = 0;
                end
            end else if (beat) begin
                m_cnt++;
                if (req_last[m_owner] || m_cnt == MB) begin
                    m_rr    = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the queued predictions.
    initial forever begin
        status_t a, e;
        beat_t   eb;
        @(negedge clk);
        #1;
        a = {busy, grant, fifo_wvalid, fifo_wdata, req_ready};
        if (st_q.size() == 0) check(1'b0, "status_queue_empty", 64'(a), 64'd0);
        else begin
            e = st_q.pop_front();
            check(a === e, "status{busy,grant,wvalid,wdata,ready}", 64'(a), 64'(e));
        end
        if (fifo_wvalid === 1'b1 && fifo_wready === 1'b1) begin
            if (beat_q.size() == 0) check(1'b0, "unexpected_beat", 64'({grant, fifo_wdata}), 64'd0);
            else begin
                eb = beat_q.pop_front();
                check({grant, fifo_wdata} === eb, "beat{grant,data}", 64'({grant, fifo_wdata}), 64'(eb));
            end
        end
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; clr = 1'b0; req_valid = '0; req_data = '0;
        req_last = '0; fifo_wready = 1'b0;
        set_cfg(100, 100, 100, 0, '0, 0, 1, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single 3-byte packet from requester 0
        pkt_q[0].push_back({1'b0, 8'h41});
        pkt_q[0].push_back({1'b0, 8'h42});
        pkt_q[0].push_back({1'b1, 8'h43});
        run(10);

        // Requesters 0 and 2 with continuous single-byte packets
        set_cfg(100, 100, 100, 0, 4'b0101, 100, 1, 0);
        run(30);

        // Backpressure with multi-byte packets
        set_cfg(90, 40, 100, 0, 4'b1111, 80, 6, 0);
        run(200);

        // Burst limit: 20 bytes without last on requester 1, others competing
        set_cfg(100, 100, 100, 0, 4'b1101, 100, 3, 0);
        make_packet(1, 20, 1'b1);
        run(80);

        // Flush pulses
        set_cfg(90, 80, 100, 5, 4'b1111, 80, 5, 0);
        run(300);

        // Enable gating: requester 3 only, enable low then high
        set_cfg(100, 100, 100, 0, '0, 0, 1, 0);
        run(40);
        set_cfg(100, 100, 0, 0, 4'b1000, 100, 3, 0);
        run(12);
        enable_pct = 100;
        run(10);

        // Reset asserted mid-traffic
        set_cfg(100, 70, 100, 0, 4'b1111, 100, 8, 0);
        run(25);
        @(posedge clk);
        #1 pop_accepted();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run(30);

        // Long mixed random run
        set_cfg(80, 70, 90, 1, 4'b1111, 60, 24, 15);
        run(3000);

        // Drain: stop requests and confirm every predicted beat was seen
        set_cfg(0, 100, 0, 0, '0, 0, 1, 0);
        run(5);
        check(beat_q.size() == 0, "pending_expected_beats", 64'(beat_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NumReq, default 4, meaning number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter MaxBurst, default 16, meaning max bytes per grant before forced release (power of two, 2..256).
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock.
REQ-004 SHALL have port rst_ni, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port enable_i, input, 1, meaning new grants allowed (tied to TX enable).
REQ-006 SHALL have port clr_i, input, 1, meaning synchronous flush (tied to TX FIFO reset pulse).
REQ-007 SHALL have port req_valid_i, input, NumReq, meaning per-requester byte valid.
REQ-008 SHALL have port req_data_i, input, 8*NumReq, meaning per-requester byte; requester i at bits [8i+7:8i].
REQ-009 SHALL have port req_last_i, input, NumReq, meaning byte is the last of a packet.
REQ-010 SHALL have port req_ready_o, output, NumReq, meaning per-requester byte accepted.
REQ-011 SHALL have port fifo_wvalid_o, output, 1, meaning write strobe to TX FIFO.
REQ-012 SHALL have port fifo_wdata_o, output, 8, meaning byte to TX FIFO.
REQ-013 SHALL have port fifo_wready_i, input, 1, meaning TX FIFO not full.
REQ-014 SHALL have port grant_o, output, NumReq, meaning one-hot current owner, zero when idle.
REQ-015 SHALL have port busy_o, output, 1, meaning a grant is held.

Function
REQ-016 SHALL implement FSM states IDLE and LOCK.
REQ-017 In IDLE with enable_i=1 and any req_valid_i set, SHALL register the owner as the first set requester searching upward from rr_ptr with wrap, enter LOCK next cycle; no byte transfers in IDLE.
REQ-018 In IDLE with enable_i=0, SHALL stay in IDLE regardless of requests.
REQ-019 In LOCK, fifo_wvalid_o SHALL equal req_valid_i[owner], fifo_wdata_o SHALL equal owner's byte, req_ready_o[owner] SHALL equal fifo_wready_i; all other req_ready_o bits SHALL be 0.
REQ-020 A beat SHALL occur when fifo_wvalid_o and fifo_wready_i are both 1 in the same cycle.
REQ-021 burst_cnt ($clog2(MaxBurst) bits) SHALL clear on entry to LOCK and increment per beat.
REQ-022 On a beat with req_last_i[owner]=1, or with burst_cnt=MaxBurst-1, SHALL return to IDLE next cycle and set rr_ptr to (owner+1) mod NumReq.
REQ-023 Owner deasserting valid mid-packet SHALL NOT release the grant; lock held until last or burst limit.
REQ-024 enable_i falling during LOCK SHALL NOT abort the current packet.
REQ-025 clr_i=1 SHALL force IDLE, rr_ptr=0, burst_cnt=0 next cycle, override all other events, and gate fifo_wvalid_o and all req_ready_o to 0 in that cycle.
REQ-026 Outside LOCK, fifo_wvalid_o, req_ready_o and grant_o SHALL be 0 and fifo_wdata_o SHALL be 8'h00.
REQ-027 busy_o SHALL be 1 exactly when state is LOCK.
REQ-028 Minimum gap between consecutive grants SHALL be one IDLE cycle; request-to-first-beat latency SHALL be one cycle when FIFO ready.

Reset
REQ-029 On rst_ni low, SHALL asynchronously set state=IDLE, owner=0, rr_ptr=0, burst_cnt=0.
REQ-030 During and after reset, all outputs SHALL be 0 until first grant.
REQ-031 Reset asserted mid-packet SHALL abandon the packet with no further beats.

Verification
REQ-032 Single packet: req 0 sends 3 bytes 0x41,0x42,0x43(last), FIFO ready -> 3 consecutive beats from cycle 1 after valid, busy_o drops next cycle, rr_ptr=1.
REQ-033 Round-robin: reqs 0 and 2 each send 1-byte packets continuously, rr_ptr=0 -> grants alternate 0,2,0,2 with one idle cycle between.
REQ-034 Backpressure: fifo_wready_i=0 for 5 cycles mid-packet -> data held stable, no beat counted, req_ready_o[owner]=0, packet resumes intact.
REQ-035 Burst limit: req 1 sends 20 bytes without last, MaxBurst=16 -> release after 16th beat, req 1 regranted only after other pending requesters served.
REQ-036 Flush: clr_i pulse at 2nd byte of a 4-byte packet -> no beat in clr cycle, IDLE next cycle, rr_ptr=0.
REQ-037 Enable gating: enable_i=0 with req 3 valid -> no grant for 10 cycles; enable_i=1 -> grant_o=4'b1000 next cycle.
